// File: rtl/drc_pkg.sv
// Shared definitions for the device-route controller: packet type codes,
// reserved port IDs and the pending-lookup entry layout.
package drc_pkg;

    localparam int DRC_TYPE_W = 6;
    localparam int DRC_ADDR_W = 16;
    localparam int DRC_PORT_W = 5;

    localparam logic [DRC_TYPE_W-1:0] TYPE_UPREQ   = 6'h01;
    localparam logic [DRC_TYPE_W-1:0] TYPE_DOWNREQ = 6'h02;
    localparam logic [DRC_TYPE_W-1:0] TYPE_UPRSP   = 6'h03;
    localparam logic [DRC_TYPE_W-1:0] TYPE_DOWNRSP = 6'h04;

    localparam logic [DRC_PORT_W-1:0] PORT_NONE    = '0;
    localparam logic [DRC_PORT_W-1:0] PORT_UNREACH = '1;

    typedef struct packed {
        logic [DRC_TYPE_W-1:0] pktType;
        logic [DRC_ADDR_W-1:0] addr;
        logic [DRC_PORT_W-1:0] srcPort;
    } pendEntry_t;

endpackage

// File: rtl/drc_pend_fifo.sv
// In-order FIFO holding descriptors whose device lookups are outstanding.
// Head entry is read combinationally so it can be retired on the pop cycle.
module drc_pend_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     iClk,
    input  logic                     iResetN,
    input  logic                     iPush,
    input  logic [DATA_W-1:0]        iPushData,
    input  logic                     iPop,
    output logic [DATA_W-1:0]        oHeadData,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    logic [DATA_W-1:0] memReg [DEPTH];
    logic [PtrW-1:0]   wrPtrReg;
    logic [PtrW-1:0]   rdPtrReg;
    logic [CntW-1:0]   countReg;
    logic              doPush;
    logic              doPop;

    assign oFull     = (countReg == CntW'(DEPTH));
    assign oEmpty    = (countReg == '0);
    assign oCount    = countReg;
    assign oHeadData = memReg[rdPtrReg];
    assign doPush    = iPush & ~oFull;
    assign doPop     = iPop & ~oEmpty;

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            memReg[wrPtrReg] <= iPushData;
        end
    end

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PtrW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PtrW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CntW'(1);
                2'b01:   countReg <= countReg - CntW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/drc_route_ctrl.sv
// Device-route controller: PEC descriptors -> DAMC lookups -> route results.
// Define DRC_TIMEOUT_EN to retire lookups that get no response within TIMEOUT cycles.
module drc_route_ctrl
    import drc_pkg::*;
#(
    parameter int                ADDR_W  = DRC_ADDR_W,
    parameter int                PORT_W  = DRC_PORT_W,
    parameter int                TYPE_W  = DRC_TYPE_W,
    parameter int                DEPTH   = 4,
    parameter logic [TYPE_W-1:0] UPREQ   = TYPE_UPREQ,
    parameter logic [TYPE_W-1:0] DOWNREQ = TYPE_DOWNREQ,
    parameter logic [TYPE_W-1:0] UPRSP   = TYPE_UPRSP,
    parameter logic [TYPE_W-1:0] DOWNRSP = TYPE_DOWNRSP,
    parameter int                TIMEOUT = 64
) (
    input  logic                    iClk,
    input  logic                    iResetN,
    input  logic                    iPktValid,
    output logic                    oPktReady,
    input  logic [TYPE_W-1:0]       iPktType,
    input  logic [ADDR_W-1:0]       iPktAddr,
    input  logic [PORT_W-1:0]       iPktPort,
    output logic                    oLookupValid,
    input  logic                    iLookupReady,
    output logic [ADDR_W-1:0]       oLookupAddr,
    input  logic                    iLookupRspValid,
    output logic                    oLookupRspReady,
    input  logic [PORT_W-1:0]       iLookupRspPortID,
    output logic                    oRouteValid,
    input  logic                    iRouteReady,
    output logic [TYPE_W-1:0]       oRouteType,
    output logic [ADDR_W-1:0]       oRouteAddr,
    output logic [PORT_W-1:0]       oRouteSrcPort,
    output logic [PORT_W-1:0]       oRouteDstPort,
    output logic                    oRouteUnreach,
    output logic [$clog2(DEPTH):0]  oPendingCnt,
    output logic [15:0]             oUnreachCnt
);

    localparam int CntW = $clog2(DEPTH) + 1;

    logic              readyEnReg;
    logic              lookupValidReg;
    logic [ADDR_W-1:0] lookupAddrReg;
    logic              routeValidReg;
    logic              routeUnreachReg;
    logic [TYPE_W-1:0] routeTypeReg;
    logic [ADDR_W-1:0] routeAddrReg;
    logic [PORT_W-1:0] routeSrcReg;
    logic [PORT_W-1:0] routeDstReg;
    logic [15:0]       unreachCntReg;

    pendEntry_t        pushEntry;
    pendEntry_t        headEntry;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CntW-1:0]   fifoCount;

    logic typeOk, pktAccept, push;
    logic rspHs, rspUnreach, rspPop, pop;
    logic dropRsp, timeoutHit;
    logic loadUnreach;
    logic [PORT_W-1:0] loadDst;

    assign typeOk = (iPktType == UPREQ) | (iPktType == DOWNREQ) |
                    (iPktType == UPRSP) | (iPktType == DOWNRSP);

    // readyEnReg keeps both ready outputs low until the first clock after reset.
    assign oPktReady       = readyEnReg & ~fifoFull & ~(lookupValidReg & ~iLookupReady);
    assign oLookupRspReady = readyEnReg & (~routeValidReg | iRouteReady);

    assign pktAccept = iPktValid & oPktReady;
    assign push      = pktAccept & typeOk;
    assign pushEntry = '{pktType: iPktType, addr: iPktAddr, srcPort: iPktPort};

    assign rspHs      = iLookupRspValid & oLookupRspReady;
    assign rspUnreach = (iLookupRspPortID == PORT_NONE) | (iLookupRspPortID == PORT_UNREACH);
    assign rspPop     = rspHs & ~dropRsp & ~fifoEmpty;
    assign pop        = rspPop | timeoutHit;

    assign loadUnreach = timeoutHit | rspUnreach;
    assign loadDst     = loadUnreach ? PORT_NONE : iLookupRspPortID;

    drc_pend_fifo #(
        .DATA_W ($bits(pendEntry_t)),
        .DEPTH  (DEPTH)
    ) uPendFifo (
        .iClk      (iClk),
        .iResetN   (iResetN),
        .iPush     (push),
        .iPushData (pushEntry),
        .iPop      (pop),
        .oHeadData (headEntry),
        .oFull     (fifoFull),
        .oEmpty    (fifoEmpty),
        .oCount    (fifoCount)
    );

`ifdef DRC_TIMEOUT_EN
    localparam int TimerW = $clog2(TIMEOUT) + 1;

    logic [TimerW-1:0] timerReg;
    logic [CntW-1:0]   issuedCntReg;
    logic [CntW-1:0]   creditReg;
    logic              lookupHs;
    logic              headIssued;

    // Lookups are issued in FIFO order, so the head has been issued whenever any entry has.
    assign lookupHs   = lookupValidReg & iLookupReady;
    assign headIssued = (issuedCntReg != '0);
    assign dropRsp    = rspHs & (creditReg != '0);
    assign timeoutHit = headIssued & (timerReg == TimerW'(TIMEOUT - 1)) &
                        oLookupRspReady & ~rspHs;

    // The timer restarts whenever the head changes, so each head gets a full window.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            timerReg     <= '0;
            issuedCntReg <= '0;
            creditReg    <= '0;
        end else begin
            issuedCntReg <= issuedCntReg + CntW'(lookupHs) - CntW'(pop);
            if (pop) begin
                timerReg <= '0;
            end else if (headIssued && timerReg != TimerW'(TIMEOUT - 1)) begin
                timerReg <= timerReg + TimerW'(1);
            end
            if (timeoutHit) begin
                creditReg <= creditReg + CntW'(1);
            end else if (dropRsp) begin
                creditReg <= creditReg - CntW'(1);
            end
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
    assign dropRsp       = 1'b0;
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            readyEnReg     <= 1'b0;
            lookupValidReg <= 1'b0;
            lookupAddrReg  <= '0;
        end else begin
            readyEnReg <= 1'b1;
            if (push) begin
                lookupValidReg <= 1'b1;
                lookupAddrReg  <= iPktAddr;
            end else if (iLookupReady) begin
                lookupValidReg <= 1'b0;
            end
        end
    end

    // Pops only happen when the output slot is free or being drained this cycle.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            routeValidReg   <= 1'b0;
            routeUnreachReg <= 1'b0;
            routeTypeReg    <= '0;
            routeAddrReg    <= '0;
            routeSrcReg     <= '0;
            routeDstReg     <= '0;
            unreachCntReg   <= '0;
        end else begin
            if (pop) begin
                routeValidReg   <= 1'b1;
                routeUnreachReg <= loadUnreach;
                routeTypeReg    <= headEntry.pktType;
                routeAddrReg    <= headEntry.addr;
                routeSrcReg     <= headEntry.srcPort;
                routeDstReg     <= loadDst;
            end else if (iRouteReady) begin
                routeValidReg <= 1'b0;
            end
            if (pop && loadUnreach && unreachCntReg != 16'hFFFF) begin
                unreachCntReg <= unreachCntReg + 16'd1;
            end
        end
    end

    assign oLookupValid  = lookupValidReg;
    assign oLookupAddr   = lookupAddrReg;
    assign oRouteValid   = routeValidReg;
    assign oRouteType    = routeTypeReg;
    assign oRouteAddr    = routeAddrReg;
    assign oRouteSrcPort = routeSrcReg;
    assign oRouteDstPort = routeDstReg;
    assign oRouteUnreach = routeUnreachReg;
    assign oPendingCnt   = fifoCount;
    assign oUnreachCnt   = unreachCntReg;

endmodule

// File: tb/tb_drc_route_ctrl.sv
// Directed testbench for drc_route_ctrl; timeout scenario runs when DRC_TIMEOUT_EN is defined.
module tb_drc_route_ctrl;

    logic        iClk = 1'b0;
    logic        iResetN = 1'b0;
    logic        iPktValid = 1'b0;
    logic        oPktReady;
    logic [5:0]  iPktType = '0;
    logic [15:0] iPktAddr = '0;
    logic [4:0]  iPktPort = '0;
    logic        oLookupValid;
    logic        iLookupReady = 1'b1;
    logic [15:0] oLookupAddr;
    logic        iLookupRspValid = 1'b0;
    logic        oLookupRspReady;
    logic [4:0]  iLookupRspPortID = '0;
    logic        oRouteValid;
    logic        iRouteReady = 1'b1;
    logic [5:0]  oRouteType;
    logic [15:0] oRouteAddr;
    logic [4:0]  oRouteSrcPort;
    logic [4:0]  oRouteDstPort;
    logic        oRouteUnreach;
    logic [2:0]  oPendingCnt;
    logic [15:0] oUnreachCnt;

    always #5 iClk = ~iClk;

    drc_route_ctrl dut (
        .iClk             (iClk),
        .iResetN          (iResetN),
        .iPktValid        (iPktValid),
        .oPktReady        (oPktReady),
        .iPktType         (iPktType),
        .iPktAddr         (iPktAddr),
        .iPktPort         (iPktPort),
        .oLookupValid     (oLookupValid),
        .iLookupReady     (iLookupReady),
        .oLookupAddr      (oLookupAddr),
        .iLookupRspValid  (iLookupRspValid),
        .oLookupRspReady  (oLookupRspReady),
        .iLookupRspPortID (iLookupRspPortID),
        .oRouteValid      (oRouteValid),
        .iRouteReady      (iRouteReady),
        .oRouteType       (oRouteType),
        .oRouteAddr       (oRouteAddr),
        .oRouteSrcPort    (oRouteSrcPort),
        .oRouteDstPort    (oRouteDstPort),
        .oRouteUnreach    (oRouteUnreach),
        .oPendingCnt      (oPendingCnt),
        .oUnreachCnt      (oUnreachCnt)
    );

    typedef struct {
        logic [5:0]  t;
        logic [15:0] a;
        logic [4:0]  s;
        logic [4:0]  d;
        logic        u;
    } route_t;

    route_t      resQ[$];
    route_t      monRoute;
    int          checkCnt = 0;
    int          passCnt = 0;
    logic [15:0] expUnreach = '0;
    logic        acc;
    logic [5:0]  burstType [5];

    // Every route handshake is captured in order for later comparison.
    always @(negedge iClk) begin
        if (iResetN && oRouteValid && iRouteReady) begin
            monRoute.t = oRouteType;
            monRoute.a = oRouteAddr;
            monRoute.s = oRouteSrcPort;
            monRoute.d = oRouteDstPort;
            monRoute.u = oRouteUnreach;
            resQ.push_back(monRoute);
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic pktCycle(input logic [5:0] t, input logic [15:0] a, input logic [4:0] p,
                            output logic accepted);
        @(posedge iClk); #1;
        iPktValid = 1'b1; iPktType = t; iPktAddr = a; iPktPort = p;
        @(negedge iClk);
        accepted = oPktReady;
        @(posedge iClk); #1;
        iPktValid = 1'b0;
        $display("pkt type=%02h addr=%04h src=%0d accepted=%0d", t, a, p, accepted);
    endtask

    task automatic sendRsp(input logic [4:0] p);
        logic ok;
        ok = 1'b0;
        @(posedge iClk); #1;
        iLookupRspValid = 1'b1; iLookupRspPortID = p;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge iClk);
            ok = oLookupRspReady;
        end
        if (ok) @(posedge iClk);
        #1;
        iLookupRspValid = 1'b0;
        $display("rsp port=%0d consumed=%0d", p, ok);
        checkVal("rsp_handshake", 32'(ok), 32'd1);
    endtask

    task automatic expectRoute(input string tag, input logic [5:0] t, input logic [15:0] a,
                               input logic [4:0] s, input logic [4:0] d, input logic u);
        route_t r;
        logic   got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge iClk); #1;
            got = (resQ.size() > 0);
        end
        checkVal({tag, "_avail"}, 32'(got), 32'd1);
        if (got) begin
            r = resQ.pop_front();
            $display("route %s type=%02h addr=%04h src=%0d dst=%0d unreach=%0d",
                     tag, r.t, r.a, r.s, r.d, r.u);
            checkVal({tag, "_type"}, 32'(r.t), 32'(t));
            checkVal({tag, "_addr"}, 32'(r.a), 32'(a));
            checkVal({tag, "_src"}, 32'(r.s), 32'(s));
            checkVal({tag, "_dst"}, 32'(r.d), 32'(d));
            checkVal({tag, "_unreach"}, 32'(r.u), 32'(u));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        burstType[0] = 6'h01; burstType[1] = 6'h02; burstType[2] = 6'h03;
        burstType[3] = 6'h04; burstType[4] = 6'h01;

        // Reset state
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        checkVal("rst_pktReady", 32'(oPktReady), 32'd0);
        checkVal("rst_lookupValid", 32'(oLookupValid), 32'd0);
        checkVal("rst_lookupAddr", 32'(oLookupAddr), 32'd0);
        checkVal("rst_rspReady", 32'(oLookupRspReady), 32'd0);
        checkVal("rst_routeValid", 32'(oRouteValid), 32'd0);
        checkVal("rst_pending", 32'(oPendingCnt), 32'd0);
        checkVal("rst_unreachCnt", 32'(oUnreachCnt), 32'd0);
        @(posedge iClk); #1;
        iResetN = 1'b1;
        @(negedge iClk);
        checkVal("rel_pktReady_early", 32'(oPktReady), 32'd0);
        @(negedge iClk);
        checkVal("rel_pktReady", 32'(oPktReady), 32'd1);

        // Single reachable lookup
        pktCycle(6'h01, 16'h1234, 5'd3, acc);
        checkVal("t1_acc", 32'(acc), 32'd1);
        @(negedge iClk);
        checkVal("t1_lookupValid", 32'(oLookupValid), 32'd1);
        checkVal("t1_lookupAddr", 32'(oLookupAddr), 32'h1234);
        checkVal("t1_pending", 32'(oPendingCnt), 32'd1);
        sendRsp(5'd7);
        expectRoute("t1", 6'h01, 16'h1234, 5'd3, 5'd7, 1'b0);
        checkVal("t1_pending_after", 32'(oPendingCnt), 32'd0);

        // Both reserved port values are unreachable
        pktCycle(6'h02, 16'h0042, 5'd2, acc);
        sendRsp(5'h1F);
        expectRoute("t2a", 6'h02, 16'h0042, 5'd2, 5'd0, 1'b1);
        pktCycle(6'h02, 16'h0042, 5'd2, acc);
        sendRsp(5'h00);
        expectRoute("t2b", 6'h02, 16'h0042, 5'd2, 5'd0, 1'b1);
        expUnreach = 16'd2;
        checkVal("t2_unreachCnt", 32'(oUnreachCnt), 32'(expUnreach));

        // Back-to-back burst fills the FIFO; the fifth is refused
        @(posedge iClk); #1;
        for (int i = 0; i < 5; i++) begin
            iPktValid = 1'b1; iPktType = burstType[i];
            iPktAddr = 16'h1000 + 16'(i); iPktPort = 5'(i + 1);
            @(negedge iClk);
            checkVal($sformatf("t3_ready%0d", i), 32'(oPktReady), (i < 4) ? 32'd1 : 32'd0);
            if (i >= 1) checkVal($sformatf("t3_lkAddr%0d", i), 32'(oLookupAddr), 32'h1000 + 32'(i - 1));
            @(posedge iClk); #1;
        end
        iPktValid = 1'b0;
        @(negedge iClk);
        checkVal("t3_pending", 32'(oPendingCnt), 32'd4);
        checkVal("t3_lookupIdle", 32'(oLookupValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sendRsp(5'(8 + i));
            expectRoute($sformatf("t3r%0d", i), burstType[i], 16'h1000 + 16'(i),
                        5'(i + 1), 5'(8 + i), 1'b0);
        end

        // Invalid type is accepted and dropped
        pktCycle(6'h3F, 16'hBEEF, 5'd4, acc);
        checkVal("t4_acc", 32'(acc), 32'd1);
        @(negedge iClk);
        checkVal("t4_lookupValid", 32'(oLookupValid), 32'd0);
        checkVal("t4_pending", 32'(oPendingCnt), 32'd0);

        // Output backpressure
        iRouteReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pktCycle(6'h01, 16'hA000 + 16'(i), 5'(4 + i), acc);
            checkVal($sformatf("t5_acc%0d", i), 32'(acc), 32'd1);
        end
        sendRsp(5'd12);
        @(negedge iClk);
        checkVal("t5_routeValid", 32'(oRouteValid), 32'd1);
        checkVal("t5_rspReady", 32'(oLookupRspReady), 32'd0);
        checkVal("t5_pending", 32'(oPendingCnt), 32'd2);
        repeat (3) @(negedge iClk);
        checkVal("t5_hold_addr", 32'(oRouteAddr), 32'hA000);
        checkVal("t5_hold_dst", 32'(oRouteDstPort), 32'd12);
        fork
            sendRsp(5'd13);
            begin
                repeat (4) @(posedge iClk);
                #1 iRouteReady = 1'b1;
            end
        join
        sendRsp(5'd14);
        expectRoute("t5r0", 6'h01, 16'hA000, 5'd4, 5'd12, 1'b0);
        expectRoute("t5r1", 6'h01, 16'hA001, 5'd5, 5'd13, 1'b0);
        expectRoute("t5r2", 6'h01, 16'hA002, 5'd6, 5'd14, 1'b0);

        // Reset mid-operation discards pending entries
        pktCycle(6'h01, 16'hB000, 5'd9, acc);
        pktCycle(6'h01, 16'hB001, 5'd10, acc);
        @(negedge iClk);
        checkVal("t6_pending", 32'(oPendingCnt), 32'd2);
        @(posedge iClk); #1;
        iResetN = 1'b0;
        @(negedge iClk);
        checkVal("t6_rst_pending", 32'(oPendingCnt), 32'd0);
        checkVal("t6_rst_pktReady", 32'(oPktReady), 32'd0);
        @(posedge iClk); #1;
        iResetN = 1'b1;
        sendRsp(5'd7);
        repeat (6) @(negedge iClk);
        checkVal("t6_no_route", 32'(resQ.size()), 32'd0);
        checkVal("t6_routeValid", 32'(oRouteValid), 32'd0);
        expUnreach = 16'd0;
        checkVal("t6_unreachCnt", 32'(oUnreachCnt), 32'(expUnreach));

`ifdef DRC_TIMEOUT_EN
        // Timeout after 64 cycles, late response dropped, next lookup resolves
        pktCycle(6'h01, 16'h5555, 5'd7, acc);
        @(posedge iClk);
        repeat (63) @(posedge iClk);
        @(negedge iClk);
        checkVal("t7_not_yet", 32'(oRouteValid), 32'd0);
        @(posedge iClk);
        @(negedge iClk);
        checkVal("t7_timeout_valid", 32'(oRouteValid), 32'd1);
        expectRoute("t7", 6'h01, 16'h5555, 5'd7, 5'd0, 1'b1);
        expUnreach = expUnreach + 16'd1;
        repeat (4) @(posedge iClk);
        sendRsp(5'd9);
        repeat (6) @(negedge iClk);
        checkVal("t7_late_dropped", 32'(resQ.size()), 32'd0);
        checkVal("t7_pending", 32'(oPendingCnt), 32'd0);
        pktCycle(6'h02, 16'h6666, 5'd8, acc);
        sendRsp(5'd10);
        expectRoute("t7n", 6'h02, 16'h6666, 5'd8, 5'd10, 1'b0);
        checkVal("t7_unreachCnt", 32'(oUnreachCnt), 32'(expUnreach));
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/drc_route_ctrl.md
Name: drc_route_ctrl

Overview:
Parametrised device-route controller. Accepts dispatched packet descriptors from the PEC and issues device-address lookups to the DAMC. Tracks up to DEPTH outstanding lookups in order and emits one route result per accepted packet: either the destination port or an unreachable indication with the source port captured for the response. Sits between the PEC dispatch stage and the packet assembler.

Parameters:
ADDR_W, 16, device address width
PORT_W, 5, port ID width; 0 and all-ones are reserved
TYPE_W, 6, packet type width
DEPTH, 4, max outstanding lookups (power of 2, >=2)
UPREQ, 6'h01, upload request type code
DOWNREQ, 6'h02, download request type code
UPRSP, 6'h03, upload response type code
DOWNRSP, 6'h04, download response type code
TIMEOUT, 64, lookup timeout in cycles (used only with DRC_TIMEOUT_EN)

Ports:
iClk  in  1  clock
iResetN  in  1  asynchronous active-low reset
iPktValid  in  1  PEC descriptor valid
oPktReady  out  1  descriptor accepted when iPktValid&oPktReady
iPktType  in  TYPE_W  packet type
iPktAddr  in  ADDR_W  destination device address
iPktPort  in  PORT_W  source (client) port
oLookupValid  out  1  DAMC lookup request valid
iLookupReady  in  1  DAMC accepts request
oLookupAddr  out  ADDR_W  address to look up
iLookupRspValid  in  1  DAMC response valid (in request order)
oLookupRspReady  out  1  response consumed when both high
iLookupRspPortID  in  PORT_W  resolved port
oRouteValid  out  1  route result valid
iRouteReady  in  1  downstream accepts result
oRouteType  out  TYPE_W  original packet type
oRouteAddr  out  ADDR_W  original device address
oRouteSrcPort  out  PORT_W  original source port
oRouteDstPort  out  PORT_W  resolved port; 0 when unreachable
oRouteUnreach  out  1  device unreachable
oPendingCnt  out  $clog2(DEPTH)+1  outstanding lookups
oUnreachCnt  out  16  saturating unreachable-result count

Behaviour:
- Reset: all outputs 0. FIFO empty. oPktReady is 1 one cycle after reset release.
- Type check: a descriptor is valid when iPktType is one of UPREQ/DOWNREQ/UPRSP/DOWNRSP. Invalid types are accepted (handshake completes) and silently dropped: no lookup, no FIFO push.
- oPktReady = (pending < DEPTH) & ~(oLookupValid & ~iLookupReady).
- Valid-type accept: the next cycle, oLookupValid=1 and oLookupAddr=iPktAddr. {type, addr, srcPort} is pushed into the pending FIFO in the same accept cycle. oLookupValid/Addr are held stable until iLookupReady, then cleared unless a new accept occurs in the same cycle (back-to-back throughput 1/cycle).
- Pending count increments on push and decrements on response pop. A simultaneous push and pop leaves it unchanged. With pending==DEPTH, oPktReady=0.
- oLookupRspReady = ~oRouteValid | iRouteReady.
- On a response handshake: pop the FIFO head and register the result the next cycle.
  - Unreachable when iLookupRspPortID==0 or all-ones: oRouteUnreach=1, oRouteDstPort=0.
  - Otherwise: oRouteUnreach=0, oRouteDstPort=iLookupRspPortID.
- A response arriving with an empty FIFO (and no drop credit) is consumed and ignored. The FIFO is not modified.
- Output register: oRouteValid and its fields are held until iRouteReady. The register can reload in the same cycle it is consumed.
- oUnreachCnt increments on each unreachable result loaded and saturates at 16'hFFFF.
- Reset mid-operation: all pending entries are discarded. Responses arriving after reset release with an empty FIFO are ignored.

Optional Feature:
DRC_TIMEOUT_EN.
- Enabled: a counter tracks cycles the FIFO head has waited since its lookup handshake. When it reaches TIMEOUT, the head is popped as an unreachable result (oRouteDstPort=0), subject to the same output-ready rule. A drop-credit counter (width $clog2(DEPTH)+1) is incremented on each timeout. Responses arriving while credit>0 are consumed, discarded, and decrement the credit. If a timeout and a response occur in the same cycle, the response wins and the timer resets.
- Disabled: lookups wait indefinitely; no timer and no drop credit exist.

Decomposition:
- Package drc_pkg: packet type codes, reserved port values (PORT_NONE=0, PORT_UNREACH=all-ones), and a struct/typedef for the pending entry {type, addr, srcPort}.
- Sub-module drc_pend_fifo: synchronous FIFO of DEPTH entries with push, pop, full, empty and count.

Test Plan:
- Single UPREQ, addr 16'h1234, srcPort 3; DAMC returns port 7 -> one result: type 6'h01, addr 16'h1234, src 3, dst 7, unreach 0.
- DOWNREQ, addr 16'h0042; DAMC returns 5'h1F, then another returns 5'h00 -> two results with unreach=1, dst 0; oUnreachCnt=2.
- Five back-to-back valid descriptors, DAMC silent -> four accepted, oPktReady=0 on the fifth, oPendingCnt=4. Responses then return in order, one per result.
- iPktType=6'h3F -> handshake completes, no oLookupValid, oPendingCnt stays 0.
- iRouteReady held low with three responses pending -> oLookupRspReady=0 after the first result; results delivered unchanged and in order once iRouteReady rises.
- DRC_TIMEOUT_EN, TIMEOUT=64, no response -> unreachable result 64 cycles after the lookup handshake. A late response at cycle 70 is dropped, and the next lookup resolves correctly.
